computational_unit_p: RTL and testbench

- Parametrised datapath for the custom micro: register banks, source-select data bus, ALU, i/m address registers and output port.
- Generalises the fixed 4-bit unit in four ways: WIDTH-wide data, NXY-deep x/y register banks, a carry flag, and a multi-cycle shift-add multiplier that produces a full double-width product and raises busy.
- Sits between the instruction decoder (drives selects and enables) and data memory/pins.

---
 rtl/computational_unit_pkg.sv | 38 +++
 rtl/computational_unit_p_seq_multiplier.sv | 68 ++++++
 rtl/computational_unit_p.sv | 139 +++++++++++++
 tb/tb_computational_unit_p.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/computational_unit_pkg.sv
// Shared definitions for the computational unit: ALU function codes,
// data bus source selects, write-enable bit positions and multiplier states.
package computational_unit_pkg;

    typedef enum logic [2:0] {
        NEG    = 3'd0,
        SUB    = 3'd1,
        ADD    = 3'd2,
        MUL    = 3'd3,
        SHIFT  = 3'd4,
        XOR    = 3'd5,
        AND    = 3'd6,
        NOT_OR = 3'd7
    } alu_fn_e;

    localparam logic [3:0] SRC_X    = 4'd0;
    localparam logic [3:0] SRC_Y    = 4'd1;
    localparam logic [3:0] SRC_R    = 4'd2;
    localparam logic [3:0] SRC_RHI  = 4'd3;
    localparam logic [3:0] SRC_M    = 4'd4;
    localparam logic [3:0] SRC_I    = 4'd5;
    localparam logic [3:0] SRC_DM   = 4'd6;
    localparam logic [3:0] SRC_IMM  = 4'd7;
    localparam logic [3:0] SRC_PINS = 4'd8;

    localparam int EN_X = 0;
    localparam int EN_Y = 1;
    localparam int EN_R = 2;
    localparam int EN_M = 3;
    localparam int EN_I = 4;
    localparam int EN_O = 5;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } mul_state_e;

endpackage

// File: rtl/computational_unit_p_seq_multiplier.sv
// Unsigned shift-add multiplier: one partial product per cycle, WIDTH cycles
// per operation. done marks the final step; product is valid while done is high
// so the owner can capture it on the same edge the FSM returns to idle.
module seq_multiplier
    import computational_unit_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CW = $clog2(WIDTH + 1);

    mul_state_e         state;
    logic [2*WIDTH-1:0] mcand;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   mplier;
    logic [CW-1:0]      count;
    logic [2*WIDTH-1:0] acc_next;

    assign acc_next = mplier[0] ? acc + mcand : acc;
    assign done     = (state == ST_MUL) && (count == CW'(1));
    assign product  = acc_next;

    // Operand latch on start, then one shift-add step per cycle until count expires
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= ST_IDLE;
            busy   <= 1'b0;
            mcand  <= '0;
            acc    <= '0;
            mplier <= '0;
            count  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        mcand  <= {{WIDTH{1'b0}}, a};
                        mplier <= b;
                        acc    <= '0;
                        count  <= CW'(WIDTH);
                        state  <= ST_MUL;
                        busy   <= 1'b1;
                    end
                end
                ST_MUL: begin
                    acc    <= acc_next;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    count  <= count - CW'(1);
                    if (done) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/computational_unit_p.sv
// Datapath of the custom micro: x/y register banks, data bus source mux,
// single-cycle ALU with zero/carry flags, sequential multiplier feeding r_hi:r,
// index/modifier address registers and the output port register.
module computational_unit_p
    import computational_unit_pkg::*;
#(
    parameter  int WIDTH = 4,
    parameter  int NXY   = 2,
    localparam int SEL_W = $clog2(NXY)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       alu_op,
    input  logic [WIDTH-1:0] imm,
    input  logic [3:0]       source_sel,
    input  logic [WIDTH-1:0] dm,
    input  logic [WIDTH-1:0] i_pins,
    input  logic [SEL_W-1:0] x_wr_sel,
    input  logic [SEL_W-1:0] y_wr_sel,
    input  logic [SEL_W-1:0] x_sel,
    input  logic [SEL_W-1:0] y_sel,
    input  logic [5:0]       reg_en,
    input  logic             i_sel,
    output logic             busy,
    output logic             r_eq_0,
    output logic             r_carry,
    output logic [WIDTH-1:0] i,
    output logic [WIDTH-1:0] data_bus,
    output logic [WIDTH-1:0] o_reg
);

    logic [WIDTH-1:0]   x_bank [NXY];
    logic [WIDTH-1:0]   y_bank [NXY];
    logic [WIDTH-1:0]   r, r_hi, m;
    logic [WIDTH-1:0]   x_op, y_op, alu_res;
    logic               alu_cy, alu_upd;
    alu_fn_e            fn;
    logic               modifier;
    logic               mul_start, mul_done;
    logic [2*WIDTH-1:0] mul_prod;

    assign fn        = alu_fn_e'(alu_op[2:0]);
    assign modifier  = alu_op[3];
    assign x_op      = (int'(x_sel) < NXY) ? x_bank[x_sel] : '0;
    assign y_op      = (int'(y_sel) < NXY) ? y_bank[y_sel] : '0;
    assign mul_start = reg_en[EN_R] && (fn == MUL) && !busy;

    seq_multiplier #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .reset   (reset),
        .start   (mul_start),
        .a       (x_op),
        .b       (y_op),
        .busy    (busy),
        .done    (mul_done),
        .product (mul_prod)
    );

    // Data bus source select; unused codes read as zero
    always_comb begin
        data_bus = '0;
        case (source_sel)
            SRC_X:    data_bus = x_op;
            SRC_Y:    data_bus = y_op;
            SRC_R:    data_bus = r;
            SRC_RHI:  data_bus = r_hi;
            SRC_M:    data_bus = m;
            SRC_I:    data_bus = i;
            SRC_DM:   data_bus = dm;
            SRC_IMM:  data_bus = imm;
            SRC_PINS: data_bus = i_pins;
            default:  data_bus = '0;
        endcase
    end

    // Single-cycle ALU; alu_upd low means r and the flags must be left alone
    always_comb begin
        alu_res = r;
        alu_cy  = 1'b0;
        alu_upd = 1'b1;
        case (fn)
            NEG:    if (modifier) alu_upd = 1'b0; else alu_res = '0 - x_op;
            SUB:    {alu_cy, alu_res} = {1'b0, x_op} - {1'b0, y_op};
            ADD:    {alu_cy, alu_res} = {1'b0, x_op} + {1'b0, y_op};
            MUL:    alu_upd = 1'b0;
            SHIFT:  if (modifier) {alu_res, alu_cy} = {1'b0, x_op};
                    else          {alu_cy, alu_res} = {x_op, 1'b0};
            XOR:    alu_res = x_op ^ y_op;
            AND:    alu_res = x_op & y_op;
            NOT_OR: alu_res = modifier ? (x_op | y_op) : ~x_op;
            default: alu_upd = 1'b0;
        endcase
    end

    // Register bank writes from the data bus
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int n = 0; n < NXY; n++) begin
                x_bank[n] <= '0;
                y_bank[n] <= '0;
            end
        end else begin
            if (reg_en[EN_X] && int'(x_wr_sel) < NXY) x_bank[x_wr_sel] <= data_bus;
            if (reg_en[EN_Y] && int'(y_wr_sel) < NXY) y_bank[y_wr_sel] <= data_bus;
        end
    end

    // Result and flags: multiplier completion, or a single-cycle op while idle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r       <= '0;
            r_hi    <= '0;
            r_eq_0  <= 1'b1;
            r_carry <= 1'b0;
        end else if (mul_done) begin
            {r_hi, r} <= mul_prod;
            r_eq_0    <= (mul_prod == '0);
            r_carry   <= 1'b0;
        end else if (reg_en[EN_R] && !busy && alu_upd) begin
            r       <= alu_res;
            r_eq_0  <= (alu_res == '0);
            r_carry <= alu_cy;
        end
    end

    // Address registers and output port
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            m     <= '0;
            i     <= '0;
            o_reg <= '0;
        end else begin
            if (reg_en[EN_M]) m <= data_bus;
            if (reg_en[EN_I]) i <= i_sel ? i + m : data_bus;
            if (reg_en[EN_O]) o_reg <= data_bus;
        end
    end

endmodule

// File: tb/tb_computational_unit_p.sv
// Bench for computational_unit_p: a WIDTH=4/NXY=2 and a WIDTH=8/NXY=4 instance
// share one stimulus stream (narrow instance sees the low bits). An arithmetic
// reference model predicts every output each cycle; directed sequences pin it.
module tb_computational_unit_p;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic [3:0] alu_op = '0, source_sel = '0;
    logic [7:0] imm = '0, dm = '0, pins = '0;
    logic [1:0] xw = '0, yw = '0, xs = '0, ys = '0;
    logic [5:0] en = '0;
    logic       isel = 1'b0;

    logic       busy4, z4, c4, busy8, z8, c8;
    logic [3:0] i4, bus4, o4;
    logic [7:0] i8, bus8, o8;

    computational_unit_p #(.WIDTH(4), .NXY(2)) u4 (
        .clk(clk), .reset(rst), .alu_op(alu_op), .imm(imm[3:0]), .source_sel(source_sel),
        .dm(dm[3:0]), .i_pins(pins[3:0]), .x_wr_sel(xw[0]), .y_wr_sel(yw[0]),
        .x_sel(xs[0]), .y_sel(ys[0]), .reg_en(en), .i_sel(isel),
        .busy(busy4), .r_eq_0(z4), .r_carry(c4), .i(i4), .data_bus(bus4), .o_reg(o4));

    computational_unit_p #(.WIDTH(8), .NXY(4)) u8 (
        .clk(clk), .reset(rst), .alu_op(alu_op), .imm(imm), .source_sel(source_sel),
        .dm(dm), .i_pins(pins), .x_wr_sel(xw), .y_wr_sel(yw),
        .x_sel(xs), .y_sel(ys), .reg_en(en), .i_sel(isel),
        .busy(busy8), .r_eq_0(z8), .r_carry(c8), .i(i8), .data_bus(bus8), .o_reg(o8));

    int checks = 0, errors = 0;
    int bc4 = 0, bc8 = 0;
    bit check_en = 1'b0;

    // ---------------- reference model ----------------
    int mx [2][4];
    int my [2][4];
    int mr [2], mrh [2], mm [2], mi [2], mo [2], mcnt [2], mprod [2];
    bit mz [2], mc [2];

    function automatic int wd(int k);  return (k == 0) ? 4 : 8; endfunction
    function automatic int nxm(int k); return (k == 0) ? 1 : 3; endfunction
    function automatic int msk(int k, int v); return v & ((1 << wd(k)) - 1); endfunction

    function automatic int bus_of(int k);
        case (source_sel)
            4'd0: return mx[k][int'(xs) & nxm(k)];
            4'd1: return my[k][int'(ys) & nxm(k)];
            4'd2: return mr[k];
            4'd3: return mrh[k];
            4'd4: return mm[k];
            4'd5: return mi[k];
            4'd6: return msk(k, int'(dm));
            4'd7: return msk(k, int'(imm));
            4'd8: return msk(k, int'(pins));
            default: return 0;
        endcase
    endfunction

    // Model state advance on each clock, cleared by reset
    always @(posedge clk or posedge rst) begin
        int bv, xv, yv, full, res, cy;
        bit upd;
        if (rst) begin
            for (int k = 0; k < 2; k++) begin
                for (int j = 0; j < 4; j++) begin
                    mx[k][j] <= 0;
                    my[k][j] <= 0;
                end
                mr[k] <= 0; mrh[k] <= 0; mm[k] <= 0; mi[k] <= 0; mo[k] <= 0;
                mz[k] <= 1'b1; mc[k] <= 1'b0; mcnt[k] <= 0; mprod[k] <= 0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                bv   = bus_of(k);
                xv   = mx[k][int'(xs) & nxm(k)];
                yv   = my[k][int'(ys) & nxm(k)];
                full = 1 << wd(k);
                if (en[0]) mx[k][int'(xw) & nxm(k)] <= bv;
                if (en[1]) my[k][int'(yw) & nxm(k)] <= bv;
                if (en[3]) mm[k] <= bv;
                if (en[4]) mi[k] <= isel ? (mi[k] + mm[k]) % full : bv;
                if (en[5]) mo[k] <= bv;
                if (mcnt[k] > 0) begin
                    mcnt[k] <= mcnt[k] - 1;
                    if (mcnt[k] == 1) begin
                        mr[k]  <= mprod[k] % full;
                        mrh[k] <= mprod[k] / full;
                        mz[k]  <= (mprod[k] == 0);
                        mc[k]  <= 1'b0;
                    end
                end else if (en[2]) begin
                    upd = 1'b1; cy = 0; res = 0;
                    case (alu_op[2:0])
                        3'd0: if (alu_op[3]) upd = 1'b0; else res = (full - xv) % full;
                        3'd1: begin res = (xv - yv + full) % full; cy = int'(xv < yv); end
                        3'd2: begin res = (xv + yv) % full; cy = int'(xv + yv >= full); end
                        3'd3: begin upd = 1'b0; mprod[k] <= xv * yv; mcnt[k] <= wd(k); end
                        3'd4: if (alu_op[3]) begin res = xv / 2; cy = xv % 2; end
                              else begin res = (xv * 2) % full; cy = int'(xv >= full / 2); end
                        3'd5: res = xv ^ yv;
                        3'd6: res = xv & yv;
                        default: res = alu_op[3] ? (xv | yv) : (full - 1 - xv);
                    endcase
                    if (upd) begin
                        mr[k] <= res;
                        mz[k] <= (res == 0);
                        mc[k] <= (cy != 0);
                    end
                end
            end
        end
    end

    // ---------------- checking ----------------
    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        if (!check_en || rst) return;
        if (busy4) bc4++;
        if (busy8) bc8++;
        chk("busy4", 32'(busy4), 32'(mcnt[0] > 0));
        chk("zero4", 32'(z4), 32'(mz[0]));
        chk("carry4", 32'(c4), 32'(mc[0]));
        chk("i4", 32'(i4), mi[0]);
        chk("o4", 32'(o4), mo[0]);
        chk("bus4", 32'(bus4), bus_of(0));
        chk("busy8", 32'(busy8), 32'(mcnt[1] > 0));
        chk("zero8", 32'(z8), 32'(mz[1]));
        chk("carry8", 32'(c8), 32'(mc[1]));
        chk("i8", 32'(i8), mi[1]);
        chk("o8", 32'(o8), mo[1]);
        chk("bus8", 32'(bus8), bus_of(1));
    endtask

    task automatic tick();
        @(negedge clk);
        compare_all();
        @(posedge clk);
        #1;
    endtask

    // Write imm into the register(s) selected by enable mask e
    task automatic wr(int e, int sel_w, int v);
        en = 6'(e); source_sel = 4'd7; imm = 8'(v); xw = 2'(sel_w); yw = 2'(sel_w);
        tick();
        en = '0;
    endtask

    task automatic alu(int op, int sx, int sy);
        alu_op = 4'(op); xs = 2'(sx); ys = 2'(sy); en = 6'b000100;
        tick();
        en = '0;
    endtask

    task automatic peek(int src);
        source_sel = 4'(src);
        #1;
    endtask

    task automatic wait_idle();
        int g = 0;
        while ((busy4 || busy8) && g < 40) begin
            tick();
            g++;
        end
        chk("idle_timeout", 32'(busy4 | busy8), 32'd0);
    endtask

    task automatic rand_cycles(int n);
        for (int c = 0; c < n; c++) begin
            alu_op = 4'($urandom); source_sel = 4'($urandom_range(0, 9));
            imm = 8'($urandom); dm = 8'($urandom); pins = 8'($urandom);
            xw = 2'($urandom); yw = 2'($urandom); xs = 2'($urandom); ys = 2'($urandom);
            en = 6'($urandom); isel = 1'($urandom);
            tick();
        end
        en = '0;
    endtask

    initial begin
        int b4, b8;
        #2 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check_en = 1'b1;
        rand_cycles(200);

        // mid-cycle reset clears everything without a clock edge
        #1 rst = 1'b1;
        #1;
        chk("rst_busy4", 32'(busy4), 0); chk("rst_busy8", 32'(busy8), 0);
        chk("rst_z4", 32'(z4), 1);       chk("rst_c4", 32'(c4), 0);
        chk("rst_i8", 32'(i8), 0);       chk("rst_o8", 32'(o8), 0);
        peek(2); chk("rst_r8", 32'(bus8), 0);
        peek(3); chk("rst_rhi8", 32'(bus8), 0);
        peek(4); chk("rst_m4", 32'(bus4), 0);
        @(posedge clk); #1 rst = 1'b0;

        // ADD with and without carry
        wr(1, 0, 3); wr(2, 0, 5); alu(2, 0, 0);
        peek(2); chk("add_r", 32'(bus4), 8); chk("add_c", 32'(c4), 0); chk("add_z", 32'(z4), 0);
        wr(1, 0, 'hC); alu(2, 0, 0);
        peek(2); chk("addc_r", 32'(bus4), 1); chk("addc_c", 32'(c4), 1);

        // 0xF * 0xF, second start dropped, x0 overwritten mid-multiply
        wr(1, 0, 'hF); wr(2, 0, 'hF);
        b4 = bc4; b8 = bc8;
        alu(3, 0, 0);
        peek(2); chk("r_old_during_mul", 32'(bus4), 1);
        tick();
        en = 6'b000101; alu_op = 4'd3; source_sel = 4'd7; imm = 8'd0; xw = 2'd0;
        tick();
        en = '0;
        wait_idle();
        chk("mul_busy4", 32'(bc4 - b4), 4); chk("mul_busy8", 32'(bc8 - b8), 8);
        peek(2); chk("mul_r4", 32'(bus4), 'h1); chk("mul_r8", 32'(bus8), 'hE1);
        peek(3); chk("mul_rhi4", 32'(bus4), 'hE); chk("mul_rhi8", 32'(bus8), 0);

        // reset during busy cycle 2 aborts the multiply
        wr(1, 0, 7); wr(2, 0, 9); alu(3, 0, 0); tick();
        #1 rst = 1'b1;
        #1;
        chk("abort_busy4", 32'(busy4), 0); chk("abort_busy8", 32'(busy8), 0);
        peek(2); chk("abort_r4", 32'(bus4), 0);
        peek(3); chk("abort_rhi8", 32'(bus8), 0);
        @(posedge clk); #1 rst = 1'b0;
        wr(1, 0, 2); wr(2, 0, 3); alu(3, 0, 0); wait_idle();
        peek(2); chk("mul23_r4", 32'(bus4), 6); chk("mul23_r8", 32'(bus8), 6);

        // index register: i + m wrap, then load from pins
        wr(8, 0, 'hE); isel = 1'b0; wr(16, 0, 3);
        isel = 1'b1; en = 6'b010000; tick(); en = '0;
        chk("i_wrap4", 32'(i4), 'h1); chk("i_sum8", 32'(i8), 'h11);
        isel = 1'b0; source_sel = 4'd8; pins = 8'h0A; en = 6'b010000; tick(); en = '0;
        chk("i_pins4", 32'(i4), 'hA); chk("i_pins8", 32'(i8), 'hA);

        // wide instance: SUB borrow, shift right, 200*100
        wr(1, 1, 100); wr(2, 3, 200); alu(1, 1, 3);
        peek(2); chk("sub_r8", 32'(bus8), 156); chk("sub_c8", 32'(c8), 1);
        wr(1, 1, 'h81); alu(12, 1, 0);
        peek(2); chk("shr_r8", 32'(bus8), 'h40); chk("shr_c8", 32'(c8), 1);
        wr(1, 1, 200); wr(2, 3, 100);
        b8 = bc8;
        alu(3, 1, 3); wait_idle();
        chk("mul8_busy", 32'(bc8 - b8), 8);
        peek(2); chk("mul8_r", 32'(bus8), 'h20);
        peek(3); chk("mul8_rhi", 32'(bus8), 'h4E);

        rand_cycles(3000);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
